// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the queued bundle
// layout, and the range check used for every imem read.
package ifetch_pkg;

    typedef enum logic [1:0] {S_INST, S_IMM, S_HALT} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] imm;
        logic        imm_valid;
        logic        fault;
    } fetch_bundle_t;

    localparam int IMM_FLAG_BIT = 3;
    localparam int BUNDLE_W     = $bits(fetch_bundle_t);

    // A read of base..base+last is out of range if the sum carries out or lands past the array.
    function automatic logic span_oob(input logic [31:0] base, input logic [31:0] last,
                                      input logic [31:0] limit);
        logic [32:0] hi;
        hi = {1'b0, base} + {1'b0, last};
        return hi[32] || (hi[31:0] >= limit);
    endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Show-ahead bundle queue: head_o always presents the oldest entry; flush empties it
// and overrides any push/pop in the same cycle.
module bundle_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = BUNDLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [W-1:0]             head_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: walks a byte-addressed imem, packs instruction + optional 64-bit
// immediate into bundles, queues them for the decoder, flushes on redirect.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en_i,
    input  logic [31:0] ld_addr_i,
    input  logic [7:0]  ld_data_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [63:0] out_imm_o,
    output logic        out_imm_valid_o,
    output logic [31:0] out_pc_o,
    output logic        out_fault_o
);
    localparam int unsigned IA        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MEM_LIMIT = 32'(IMEM_BYTES);

    logic [7:0]    imem_q [IMEM_BYTES];
    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d, lat_pc_q, lat_pc_d, lat_inst_q, lat_inst_d;
    logic [31:0]   rd_addr [8];
    logic [7:0]    rd_byte [8];
    logic [31:0]   fetch_inst;
    logic [63:0]   fetch_imm;
    logic          inst_fault, imm_fault;
    logic          push, full, empty;
    logic [CW-1:0] count;
    fetch_bundle_t push_bundle, head;

    always_ff @(posedge clk) begin
        if (ld_en_i && (ld_addr_i < MEM_LIMIT)) imem_q[ld_addr_i[IA-1:0]] <= ld_data_i;
    end

    // Eight-byte window at pc; bytes past the array read as zero and are never used.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            rd_addr[k] = pc_q + 32'(k);
            rd_byte[k] = (rd_addr[k] < MEM_LIMIT) ? imem_q[rd_addr[k][IA-1:0]] : 8'h00;
        end
    end

    assign fetch_inst = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
    assign fetch_imm  = {rd_byte[7], rd_byte[6], rd_byte[5], rd_byte[4],
                         rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
    assign inst_fault = (pc_q[1:0] != 2'b00) || span_oob(pc_q, 32'd3, MEM_LIMIT);
    assign imm_fault  = span_oob(pc_q, 32'd7, MEM_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INST;
            pc_q       <= RESET_PC;
            lat_pc_q   <= '0;
            lat_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lat_pc_q   <= lat_pc_d;
            lat_inst_q <= lat_inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_en_i) begin
            state_d = S_INST;
        end else begin
            case (state_q)
                S_INST: if (count != CW'(FIFO_DEPTH)) begin
                    if (inst_fault)                     state_d = S_HALT;
                    else if (fetch_inst[IMM_FLAG_BIT])  state_d = S_IMM;
                end
                S_IMM:  if (!full) state_d = imm_fault ? S_HALT : S_INST;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        push        = 1'b0;
        push_bundle = '0;
        pc_d        = pc_q;
        lat_pc_d    = lat_pc_q;
        lat_inst_d  = lat_inst_q;
        if (redirect_en_i) begin
            pc_d = redirect_pc_i;
        end else begin
            case (state_q)
                S_INST: if (count != CW'(FIFO_DEPTH)) begin
                    push_bundle.pc = pc_q;
                    if (inst_fault) begin
                        push              = 1'b1;
                        push_bundle.fault = 1'b1;
                    end else if (fetch_inst[IMM_FLAG_BIT]) begin
                        lat_pc_d   = pc_q;
                        lat_inst_d = fetch_inst;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        push             = 1'b1;
                        push_bundle.inst = fetch_inst;
                        pc_d             = pc_q + 32'd4;
                    end
                end
                S_IMM: if (!full) begin
                    push           = 1'b1;
                    push_bundle.pc = lat_pc_q;
                    if (imm_fault) begin
                        push_bundle.fault = 1'b1;
                    end else begin
                        push_bundle.inst      = lat_inst_q;
                        push_bundle.imm       = fetch_imm;
                        push_bundle.imm_valid = 1'b1;
                        pc_d                  = pc_q + 32'd8;
                    end
                end
                default: ;
            endcase
        end
    end

    bundle_fifo #(.DEPTH(FIFO_DEPTH), .W(BUNDLE_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_bundle),
        .pop_i   (out_valid_o && out_ready_i),
        .flush_i (redirect_en_i),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .head_o  (head)
    );

    assign out_valid_o     = !empty;
    assign out_pc_o        = head.pc;
    assign out_inst_o      = head.inst;
    assign out_imm_o       = head.imm;
    assign out_imm_valid_o = head.imm_valid;
    assign out_fault_o     = head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed scenarios plus random images checked against a sequential program-walk
// model of the fetch stream.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int unsigned IMEM = 1024;

    logic        clk = 1'b0, rst = 1'b1, ld_en = 1'b0, redirect_en = 1'b0, out_ready = 1'b0;
    logic [31:0] ld_addr = '0, redirect_pc = '0;
    logic [7:0]  ld_data = '0;
    logic        out_valid, out_imm_valid, out_fault;
    logic [31:0] out_inst, out_pc;
    logic [63:0] out_imm;

    ifetch_unit #(.IMEM_BYTES(IMEM), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_en_i         (ld_en),
        .ld_addr_i       (ld_addr),
        .ld_data_i       (ld_data),
        .redirect_en_i   (redirect_en),
        .redirect_pc_i   (redirect_pc),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_inst_o      (out_inst),
        .out_imm_o       (out_imm),
        .out_imm_valid_o (out_imm_valid),
        .out_pc_o        (out_pc),
        .out_fault_o     (out_fault)
    );

    always #5 clk = ~clk;

    logic [7:0]    img [IMEM];
    fetch_bundle_t exp_q [$];
    int            checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fetch_bundle_t head();
        fetch_bundle_t b;
        b.pc = out_pc; b.inst = out_inst; b.imm = out_imm;
        b.imm_valid = out_imm_valid; b.fault = out_fault;
        return b;
    endfunction

    function automatic fetch_bundle_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic [63:0] imm, input logic iv, input logic f);
        fetch_bundle_t b;
        b.pc = pc; b.inst = inst; b.imm = imm; b.imm_valid = iv; b.fault = f;
        return b;
    endfunction

    // Walk the program image from start until the first fault, listing every bundle.
    function automatic void build(input longint unsigned start);
        longint unsigned pc;
        logic [31:0] inst;
        logic [63:0] imm;
        pc = start;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            if ((pc % 4 != 0) || (pc + 3 >= IMEM)) begin
                exp_q.push_back(mk(32'(pc), 0, 0, 0, 1));
                return;
            end
            for (int b = 0; b < 4; b++) inst[8*b +: 8] = img[int'(pc) + b];
            if (!inst[3]) begin
                exp_q.push_back(mk(32'(pc), inst, 0, 0, 0));
                pc += 4;
            end else if (pc + 11 >= IMEM) begin
                exp_q.push_back(mk(32'(pc), 0, 0, 0, 1));
                return;
            end else begin
                for (int b = 0; b < 8; b++) imm[8*b +: 8] = img[int'(pc) + 4 + b];
                exp_q.push_back(mk(32'(pc), inst, imm, 1, 0));
                pc += 12;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program image is written while reset is held; imem is not reset.
    task automatic reset_load();
        rst = 1'b1;
        for (int i = 0; i < int'(IMEM); i++) begin
            ld_en = 1'b1; ld_addr = i; ld_data = img[i];
            step();
        end
        ld_en = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < int'(IMEM); i++) img[i] = 8'h00;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_en = 1'b1; redirect_pc = pc;
        step();
        redirect_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        fetch_bundle_t prev, e;
        logic hold, rdy;
        int cyc;
        hold = 1'b0; cyc = 0; prev = '0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            if (hold) chk({tag, "_hold"}, head(), prev);
            rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (out_valid && rdy) begin
                e = exp_q.pop_front();
                chk({tag, "_bundle"}, head(), e);
            end
            hold = out_valid && !rdy;
            prev = head();
            step();
            cyc++;
        end
        chk({tag, "_drained"}, 130'(exp_q.size()), 130'd0);
        out_ready = 1'b1;
    endtask

    task automatic halt_check(input string tag);
        repeat (8) begin
            chk(tag, out_valid, 1'b0);
            step();
        end
    endtask

    initial begin
        int unsigned rpc;

        // Two plain instructions back to back, plus reset values.
        clear_img(); img[0] = 8'h01; img[4] = 8'h02;
        out_ready = 1'b1;
        reset_load();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_imm", out_imm, 64'h0);
        chk("rst_flags", {out_imm_valid, out_fault}, 2'b00);
        rst = 1'b0;
        step();
        chk("t1_b0", head(), mk(32'h0, 32'h1, 0, 0, 0));
        chk("t1_v0", out_valid, 1'b1);
        step();
        chk("t1_b1", head(), mk(32'h4, 32'h2, 0, 0, 0));

        // Instruction with immediate: two-cycle latency, then pc skips to 12.
        clear_img(); img[0] = 8'h08;
        for (int b = 0; b < 8; b++) img[4 + b] = 8'h88 - 8'(b * 8'h11);
        reset_load();
        rst = 1'b0;
        step();
        chk("t2_lat", out_valid, 1'b0);
        step();
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_b0", head(), mk(32'h0, 32'h8, 64'h1122_3344_5566_7788, 1, 0));
        step();
        chk("t2_b1", head(), mk(32'hC, 32'h0, 0, 0, 0));

        // Backpressure: head stable, then five bundles in order with no gap.
        clear_img();
        out_ready = 1'b0;
        reset_load();
        rst = 1'b0;
        repeat (10) begin
            step();
            chk("t3_stall", head(), mk(32'h0, 32'h0, 0, 0, 0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", out_valid, 1'b1);
            chk("t3_pc", out_pc, 32'(4 * i));
            step();
        end

        // Redirect with three queued: nothing popped, next head is the target.
        clear_img(); img[32'h40] = 8'h77;
        out_ready = 1'b0;
        reset_load();
        rst = 1'b0;
        repeat (3) step();
        chk("t4_queued", out_pc, 32'h0);
        out_ready = 1'b1;
        redirect(32'h40);
        out_ready = 1'b0;
        chk("t4_flushed", out_valid, 1'b0);
        step();
        chk("t4_target", head(), mk(32'h40, 32'h77, 0, 0, 0));

        // Immediate overruns the end of imem: fault bundle, halt, then resume.
        clear_img(); img[1020] = 8'h08;
        out_ready = 1'b1;
        reset_load();
        rst = 1'b0;
        build(0);
        chk("t5_model_tail", exp_q[exp_q.size() - 1], mk(32'd1020, 0, 0, 0, 1));
        drain("t5");
        halt_check("t5_halt");
        redirect(32'h0);
        chk("t5_redir_gap", out_valid, 1'b0);
        step();
        chk("t5_resume", head(), mk(32'h0, 32'h0, 0, 0, 0));
        chk("t5_resume_v", out_valid, 1'b1);

        // Asynchronous reset mid-stream.
        clear_img(); img[0] = 8'h05;
        out_ready = 1'b0;
        reset_load();
        rst = 1'b0;
        step(); step();
        chk("t6_queued", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1 chk("t6_async", out_valid, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("t6_first", head(), mk(32'h0, 32'h5, 0, 0, 0));
        chk("t6_first_v", out_valid, 1'b1);

        // Random images, random decoder backpressure, random redirect targets.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < int'(IMEM); i++) img[i] = 8'($urandom);
            reset_load();
            rst = 1'b0;
            build(0);
            drain("rnd_boot");
            halt_check("rnd_boot_halt");
            rpc = $urandom_range(0, 1060);
            if ($urandom_range(0, 3) != 0) rpc = rpc & ~32'd3;
            redirect(rpc);
            chk("rnd_redir_gap", out_valid, 1'b0);
            build(rpc);
            drain("rnd_redir");
            halt_check("rnd_redir_halt");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
